lfo_wave_gen: RTL

Parametrised LFO waveform core that replaces the constant DAC code in the LFO top level. It holds a phase accumulator and produces one sample per request from the DAC interface over a data_req/data_ack handshake. Waveforms are triangle, saw-up, square and saw-down. Rate and depth are adjusted by encoder cw/ccw pulses, and the waveform is cycled by a button pulse.

---
 rtl/lfo_dac_if.sv | 22 ++
 rtl/lfo_wave_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lfo_dac_if.sv
// Sample handshake between the LFO waveform core and the DAC interface.
// The DAC side (master) raises data_req; the core (slave) returns data with data_ack.
`timescale 1ns/1ps
interface lfo_dac_if #(
    parameter int unsigned DATA_W = 12
);
    logic              data_req;
    logic [DATA_W-1:0] data;
    logic              data_ack;

    modport master (
        output data_req,
        input  data,
        input  data_ack
    );

    modport slave (
        input  data_req,
        output data,
        output data_ack
    );
endinterface

// File: rtl/lfo_wave_gen.sv
// LFO waveform core: phase accumulator, depth-scaled tri/saw/square samples served per DAC request.
// Optional LFO_PHASE_SYNC_EN adds a phase_sync pulse input that clears the accumulator.
`timescale 1ns/1ps
module lfo_wave_gen #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned PHASE_W   = 24,
    parameter int unsigned RATE_W    = 16,
    parameter int unsigned RATE_INIT = 256,
    parameter int unsigned DEPTH_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rate_up,
    input  logic              rate_dn,
    input  logic              depth_up,
    input  logic              depth_dn,
    input  logic              wave_next,
`ifdef LFO_PHASE_SYNC_EN
    input  logic              phase_sync,
`endif
    lfo_dac_if.slave          dac,
    output logic [1:0]        wave_sel,
    output logic [RATE_W-1:0] rate
);

    localparam int unsigned SW     = DATA_W + 1;
    localparam int unsigned PW     = DATA_W + DEPTH_W + 2;
    localparam int unsigned DW1    = DEPTH_W + 1;
    localparam int unsigned MID    = 2 ** (DATA_W - 1);

    localparam logic [RATE_W-1:0]    RATE_MAX  = '1;
    localparam logic [RATE_W-1:0]    RATE_MIN  = RATE_W'(1);
    localparam logic [DEPTH_W:0]     DEPTH_MAX = DW1'(2 ** DEPTH_W);
    localparam logic signed [PW-1:0] MID_S     = PW'(MID);
    localparam logic signed [PW-1:0] OUT_MAX   = PW'(2 ** DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ACK,
        S_WAIT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 ack_d;
    logic                 load_c;

    logic [PHASE_W-1:0]   phase_q;
    logic [DEPTH_W:0]     depth_q;

    logic                 msb_c;
    logic [DATA_W-1:0]    tri_t_c;
    logic [DATA_W-1:0]    saw_c;
    logic [DATA_W-1:0]    raw_c;
    logic signed [SW-1:0] s_c;
    logic signed [DEPTH_W+1:0] depth_s_c;
    logic signed [PW-1:0] prod_c;
    logic signed [PW-1:0] scaled_c;
    logic signed [PW-1:0] sum_c;
    logic [DATA_W-1:0]    sample_c;

    // Rate: saturating 1..2**RATE_W-1, simultaneous up/down cancels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate <= RATE_W'(RATE_INIT);
        end else if (rate_up && !rate_dn && rate != RATE_MAX) begin
            rate <= rate + RATE_W'(1);
        end else if (rate_dn && !rate_up && rate > RATE_MIN) begin
            rate <= rate - RATE_W'(1);
        end
    end

    // Depth: saturating 0..2**DEPTH_W, simultaneous up/down cancels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_q <= DEPTH_MAX;
        end else if (depth_up && !depth_dn && depth_q != DEPTH_MAX) begin
            depth_q <= depth_q + DW1'(1);
        end else if (depth_dn && !depth_up && depth_q != '0) begin
            depth_q <= depth_q - DW1'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wave_sel <= 2'd0;
        end else if (wave_next) begin
            wave_sel <= wave_sel + 2'd1;
        end
    end

    // Phase accumulator advances once per computed sample and wraps silently
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
`ifdef LFO_PHASE_SYNC_EN
        end else if (phase_sync) begin
            phase_q <= '0;
`endif
        end else if (load_c) begin
            phase_q <= phase_q + PHASE_W'(rate);
        end
    end

    // Raw waveform selection followed by signed depth scaling around midscale
    always_comb begin
        msb_c    = phase_q[PHASE_W-1];
        tri_t_c  = phase_q[PHASE_W-2 -: DATA_W];
        saw_c    = phase_q[PHASE_W-1 -: DATA_W];
        raw_c    = '0;
        sample_c = '0;
        case (wave_sel)
            2'd0:    raw_c = msb_c ? ~tri_t_c : tri_t_c;
            2'd1:    raw_c = saw_c;
            2'd2:    raw_c = msb_c ? '1 : '0;
            default: raw_c = ~saw_c;
        endcase
        s_c       = $signed({1'b0, raw_c}) - $signed(SW'(MID));
        depth_s_c = $signed({1'b0, depth_q});
        prod_c    = PW'(s_c) * PW'(depth_s_c);
        scaled_c  = prod_c >>> DEPTH_W;
        sum_c     = scaled_c + MID_S;
        if (sum_c < 0) begin
            sample_c = '0;
        end else if (sum_c > OUT_MAX) begin
            sample_c = '1;
        end else begin
            sample_c = sum_c[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake next-state; data_ack is registered from the next state
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dac.data_req) state_d = S_CALC;
            end
            S_CALC: begin
                load_c  = 1'b1;
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = dac.data_req ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!dac.data_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ack_d = (state_d == S_ACK) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac.data     <= DATA_W'(MID);
            dac.data_ack <= 1'b0;
        end else begin
            dac.data_ack <= ack_d;
            if (load_c) dac.data <= sample_c;
        end
    end

endmodule
